// File: rtl/mp_ram_bypass.sv
// Multi-read-port RAM with one bit-masked write port and a configurable collision bypass.
// Read latency of 1 or 2 cycles; write-first or read-old behaviour on address collisions.
module mp_ram_bypass #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int RD_LATENCY = 1,
  parameter int RW_MODE    = 1
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         CEB,
  input  logic [ADDR_WIDTH-1:0]        AB,
  input  logic [DATA_WIDTH-1:0]        DB,
  input  logic [DATA_WIDTH-1:0]        BWB,
  input  logic [NUM_RD-1:0]            CEA,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] AA,
  output logic [NUM_RD*DATA_WIDTH-1:0] QA,
  output logic [NUM_RD-1:0]            QA_VALID
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("mp_ram_bypass: RD_LATENCY must be 1 or 2");
  end
  if (RW_MODE != 0 && RW_MODE != 1) begin : g_bad_rw_mode
    $error("mp_ram_bypass: RW_MODE must be 0 or 1");
  end
  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("mp_ram_bypass: NUM_RD must be in 1..4");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array is deliberately not reset; writes are blocked while reset is held.
  always_ff @(posedge CLK) begin
    if (!rst && CEB) begin
      mem[AB] <= (mem[AB] & ~BWB) | (DB & BWB);
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  collide;
    logic [DATA_WIDTH-1:0] q_r;
    logic                  v_r;

    assign rd_addr = AA[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_word = mem[rd_addr];
    assign collide = CEB && (rd_addr == AB);
    assign rd_data = (RW_MODE == 1 && collide) ? ((rd_word & ~BWB) | (DB & BWB)) : rd_word;

    assign QA[i*DATA_WIDTH +: DATA_WIDTH] = q_r;
    assign QA_VALID[i]                    = v_r;

    if (RD_LATENCY == 1) begin : g_lat1
      always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
          q_r <= '0;
          v_r <= 1'b0;
        end else begin
          v_r <= CEA[i];
          if (CEA[i]) begin
            q_r <= rd_data;
          end
        end
      end
    end else begin : g_lat2
      logic                  s1_valid;
      logic [ADDR_WIDTH-1:0] s1_addr;
      logic [DATA_WIDTH-1:0] s1_data;
      logic [DATA_WIDTH-1:0] s1_final;

      // Write-first also folds in a write landing one edge after the read was issued.
      assign s1_final = (RW_MODE == 1 && CEB && (AB == s1_addr)) ?
                        ((s1_data & ~BWB) | (DB & BWB)) : s1_data;

      always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
          s1_valid <= 1'b0;
          s1_addr  <= '0;
          s1_data  <= '0;
          q_r      <= '0;
          v_r      <= 1'b0;
        end else begin
          s1_valid <= CEA[i];
          if (CEA[i]) begin
            s1_addr <= rd_addr;
            s1_data <= rd_data;
          end
          v_r <= s1_valid;
          if (s1_valid) begin
            q_r <= s1_final;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mp_ram_bypass.sv
// Scoreboard bench: four configurations (latency 1/2 x write-first/read-old) share one stimulus stream.
// A bench-side memory model predicts each port's delivered word and delivery edge.
module tb_mp_ram_bypass;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NR = 2;

  logic           CLK;
  logic           rst;
  logic           CEB;
  logic [AW-1:0]  AB;
  logic [DW-1:0]  DB;
  logic [DW-1:0]  BWB;
  logic [NR-1:0]  CEA;
  logic [NR*AW-1:0] AA;
  logic [NR*DW-1:0] qa_w [4];
  logic [NR-1:0]    qv_w [4];

  // dut 0: lat1 write-first, 1: lat1 read-old, 2: lat2 write-first, 3: lat2 read-old
  mp_ram_bypass u_wf1 (.CLK(CLK), .rst(rst), .CEB(CEB), .AB(AB), .DB(DB), .BWB(BWB),
                       .CEA(CEA), .AA(AA), .QA(qa_w[0]), .QA_VALID(qv_w[0]));
  mp_ram_bypass #(.RW_MODE(0)) u_ro1 (.CLK(CLK), .rst(rst), .CEB(CEB), .AB(AB), .DB(DB), .BWB(BWB),
                       .CEA(CEA), .AA(AA), .QA(qa_w[1]), .QA_VALID(qv_w[1]));
  mp_ram_bypass #(.RD_LATENCY(2)) u_wf2 (.CLK(CLK), .rst(rst), .CEB(CEB), .AB(AB), .DB(DB), .BWB(BWB),
                       .CEA(CEA), .AA(AA), .QA(qa_w[2]), .QA_VALID(qv_w[2]));
  mp_ram_bypass #(.RD_LATENCY(2), .RW_MODE(0)) u_ro2 (.CLK(CLK), .rst(rst), .CEB(CEB), .AB(AB), .DB(DB),
                       .BWB(BWB), .CEA(CEA), .AA(AA), .QA(qa_w[3]), .QA_VALID(qv_w[3]));

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [8][$];
  logic [31:0] last_q [8];
  logic [31:0] mdl [64];
  logic        pend_v [2];
  logic [5:0]  pend_a [2];
  logic [31:0] pend_d [2];
  int          edge_n;
  int          n_cmp;
  int          n_bad;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                        input logic [31:0] m);
    return (old_w & ~m) | (d & m);
  endfunction

  function automatic exp_t mk(input int due, input logic [31:0] data);
    exp_t e;
    e.due  = due;
    e.data = data;
    return e;
  endfunction

  // Predict the coming edge from the inputs currently driven, then take the edge.
  task automatic step();
    logic [5:0]  a;
    logic [31:0] old_w, wf;
    if (!rst) begin
      for (int p = 0; p < NR; p++) begin
        if (pend_v[p]) begin
          wf = (CEB && AB == pend_a[p]) ? merge(pend_d[p], DB, BWB) : pend_d[p];
          sb[4+p].push_back(mk(edge_n + 1, wf));
          pend_v[p] = 1'b0;
        end
      end
      for (int p = 0; p < NR; p++) begin
        if (CEA[p]) begin
          a     = AA[p*AW +: AW];
          old_w = mdl[a];
          wf    = (CEB && AB == a) ? merge(old_w, DB, BWB) : old_w;
          sb[0+p].push_back(mk(edge_n + 1, wf));
          sb[2+p].push_back(mk(edge_n + 1, old_w));
          sb[6+p].push_back(mk(edge_n + 2, old_w));
          pend_v[p] = 1'b1;
          pend_a[p] = a;
          pend_d[p] = wf;
        end
      end
      if (CEB) mdl[AB] = merge(mdl[AB], DB, BWB);
    end
    @(posedge CLK);
    edge_n++;
    #1;
  endtask

  task automatic idle();
    CEB = 1'b0;
    CEA = '0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [31:0] m);
    CEB = 1'b1;
    AB  = a;
    DB  = d;
    BWB = m;
  endtask

  task automatic rd(input int p, input logic [5:0] a);
    CEA[p]          = 1'b1;
    AA[p*AW +: AW]  = a;
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sb[k].delete();
      last_q[k] = '0;
    end
    for (int p = 0; p < NR; p++) pend_v[p] = 1'b0;
  endtask

  always @(negedge CLK) begin
    int   k;
    logic ev;
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      for (int p = 0; p < NR; p++) begin
        k  = d*2 + p;
        ev = (sb[k].size() > 0) && (sb[k][0].due == edge_n);
        check_eq($sformatf("d%0d p%0d valid", d, p), {63'd0, qv_w[d][p]}, {63'd0, ev});
        if (ev) begin
          e = sb[k].pop_front();
          last_q[k] = e.data;
        end
        check_eq($sformatf("d%0d p%0d data", d, p), {32'd0, qa_w[d][p*DW +: DW]}, {32'd0, last_q[k]});
      end
    end
  end

  initial begin
    int left;
    n_cmp  = 0;
    n_bad  = 0;
    edge_n = 0;
    for (int k = 0; k < 8; k++) last_q[k] = '0;
    for (int p = 0; p < NR; p++) pend_v[p] = 1'b0;
    for (int a = 0; a < 64; a++) mdl[a] = '0;
    rst = 1'b1;
    CEB = 1'b0; AB = '0; DB = '0; BWB = '0; CEA = '0; AA = '0;
    // Requests held during reset must be ignored.
    wr(6'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    rd(0, 6'd1);
    step();
    step();
    check_eq("reset qa", {32'd0, qa_w[2][31:0]}, 64'd0);
    check_eq("reset valid", {62'd0, qv_w[0]}, 64'd0);
    idle();
    rst = 1'b0;

    for (int a = 0; a < 64; a++) begin
      wr(a[5:0], 32'h5A5A0000 ^ (a * 32'h01010101), 32'hFFFFFFFF);
      step();
    end
    wr(6'd3, 32'hFFFF0000, 32'hFFFFFFFF); step();
    wr(6'd7, 32'h00000000, 32'hFFFFFFFF); step();
    wr(6'd9, 32'h11111111, 32'hFFFFFFFF); step();
    wr(6'd5, 32'hDEADBEEF, 32'hFFFFFFFF); step();
    idle();

    rd(0, 6'd5); step(); idle();
    check_eq("basic read", {32'd0, qa_w[0][31:0]}, {32'd0, 32'hDEADBEEF});
    check_eq("basic valid", {62'd0, qv_w[0]}, 64'd1);
    step(); step(); step();
    check_eq("basic hold", {32'd0, qa_w[0][31:0]}, {32'd0, 32'hDEADBEEF});

    wr(6'd3, 32'h12345678, 32'h0000FFFF); step(); idle();
    rd(1, 6'd3); step(); idle();
    check_eq("partial write", {32'd0, qa_w[0][63:32]}, {32'd0, 32'hFFFF5678});
    step(); step();

    wr(6'd7, 32'hA5A5A5A5, 32'hFF00FF00);
    rd(0, 6'd7); rd(1, 6'd7); step(); idle();
    check_eq("coll wf", qa_w[0], {32'hA500A500, 32'hA500A500});
    check_eq("coll ro", qa_w[1], 64'd0);
    step(); step();

    rd(0, 6'd9); step(); idle();
    check_eq("lat2 not yet", {62'd0, qv_w[2]}, 64'd0);
    wr(6'd9, 32'h22222222, 32'h0000FFFF); step(); idle();
    check_eq("lat2 merge", {32'd0, qa_w[2][31:0]}, {32'd0, 32'h11112222});
    check_eq("lat2 ro", {32'd0, qa_w[3][31:0]}, {32'd0, 32'h11111111});
    step(); step();

    rd(0, 6'd5); rd(1, 6'd3); step(); idle();
    assert_reset();
    #1;
    check_eq("mid reset qa", qa_w[2], 64'd0);
    step(); step();
    rst = 1'b0;
    step(); step();
    rd(0, 6'd5); step(); idle();
    check_eq("post reset", {32'd0, qa_w[0][31:0]}, {32'd0, 32'hDEADBEEF});
    step(); step();

    for (int k = 0; k < 16; k++) begin
      wr((k % 2 == 1) ? 6'(k) : 6'((k + 63) % 64), $urandom, $urandom);
      rd(0, 6'(k));
      rd(1, 6'(15 - k));
      step();
    end
    idle();
    for (int k = 0; k < 4; k++) step();

    left = 0;
    for (int k = 0; k < 8; k++) left += sb[k].size();
    check_eq("drained", 64'(left), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
